// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the serial ALU.
//   - Operation encodings driven on Sel / seen by every slice.
//   - Controller state type (IDLE, RUN, DONE).
//   - isArith(): true for the ops that use the carry/borrow chain.
package alu_pkg;

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_ADD = 2'b10;
  localparam logic [1:0] OP_SUB = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } aluState_e;

  // ADD and SUB share the upper encoding bit, which is what gates the carry
  // register and the overflow flag.
  function automatic logic isArith(input logic [1:0] sel);
    return sel[1];
  endfunction

endpackage

// File: rtl/alu_serial_slice.sv
// alu_slice: combinational 1-bit ALU slice, chained SLICES times per digit.
// Ports:
//   a, b  - operand bits
//   cin   - carry-in (ADD) or borrow-in (SUB) from the previous slice
//   sel   - operation (alu_pkg OP_* encoding)
//   res   - result bit
//   cout  - carry/borrow to the next slice; 0 for the logic ops
module alu_slice
  import alu_pkg::*;
(
  input  logic       a,
  input  logic       b,
  input  logic       cin,
  input  logic [1:0] sel,
  output logic       res,
  output logic       cout
);

  // Sum and difference bits are identical (a^b^c); only the carry term
  // differs: a borrow is generated when the minuend bit is 0, hence ~a.
  always_comb begin
    res  = 1'b0;
    cout = 1'b0;
    case (sel)
      OP_AND: res = a & b;
      OP_OR:  res = a | b;
      OP_ADD: begin
        res  = a ^ b ^ cin;
        cout = (a & b) | (a & cin) | (b & cin);
      end
      default: begin
        res  = a ^ b ^ cin;
        cout = (~a & b) | (~a & cin) | (b & cin);
      end
    endcase
  end

endmodule

// File: rtl/alu_serial.sv
// alu_serial: multi-cycle ALU processing WIDTH-bit operands SLICES bits per
// clock (N = WIDTH/SLICES digits, LSB digit first) with a registered carry.
// Parameters:
//   WIDTH  - operand/result width (>= 2)
//   SLICES - bits per cycle, must divide WIDTH
// Ports:
//   Clk, Reset      - rising-edge clock, synchronous active-high reset
//   Start / Ready   - operand handshake, accepted only in IDLE
//   Sel, A, B       - operation and operands, latched at accept
//   CarryIn         - carry-in (ADD) / borrow-in (SUB), ignored for logic ops
//   Valid           - one-cycle pulse when ResAlu/CarryOut are final
//   ResAlu          - result, held until the next accepted Start
//   CarryOut        - carry (ADD) / borrow (SUB) out of the MSB, 0 otherwise
// Optional build macro ALU_SERIAL_FLAGS_EN adds registered outputs:
//   Zero            - ResAlu == 0
//   Overflow        - signed overflow for ADD/SUB, 0 for logic ops
module alu_serial
  import alu_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int SLICES = 1
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [1:0]       Sel,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             CarryIn,
  output logic             Ready,
  output logic             Valid,
  output logic [WIDTH-1:0] ResAlu,
  output logic             CarryOut
`ifdef ALU_SERIAL_FLAGS_EN
  ,
  output logic             Zero,
  output logic             Overflow
`endif
);

  localparam int N     = WIDTH / SLICES;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST_DIGIT = CNT_W'(N - 1);

  aluState_e        state;
  aluState_e        stateNext;
  logic             accept;
  logic             lastDigit;
  logic [CNT_W-1:0] digitCnt;
  logic [WIDTH-1:0] aReg;
  logic [WIDTH-1:0] bReg;
  logic [1:0]       selReg;
  logic             carryReg;
  logic [SLICES-1:0] aDigit;
  logic [SLICES-1:0] bDigit;
  logic [SLICES-1:0] sliceRes;
  logic [SLICES:0]   chain;
  logic [WIDTH-1:0]  resMerged;

  // Controller state register.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Next-state logic. Start is only looked at in IDLE, so requests arriving
  // while busy simply vanish. lastDigit marks the cycle that finishes the
  // operation and lets the datapath capture the final carry and flags.
  always_comb begin
    stateNext = state;
    accept    = 1'b0;
    lastDigit = 1'b0;
    case (state)
      IDLE: begin
        if (Start) begin
          stateNext = RUN;
          accept    = 1'b1;
        end
      end
      RUN: begin
        if (digitCnt == LAST_DIGIT) begin
          stateNext = DONE;
          lastDigit = 1'b1;
        end
      end
      DONE: stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Pick the current digit out of the latched operands; the registers stay
  // static and the counter walks the index instead of shifting them.
  always_comb begin
    aDigit = aReg[int'(digitCnt)*SLICES +: SLICES];
    bDigit = bReg[int'(digitCnt)*SLICES +: SLICES];
  end

  // Ripple chain for one digit, seeded by the carry register.
  assign chain[0] = carryReg;

  for (genvar i = 0; i < SLICES; i++) begin : gSlice
    alu_slice uSlice (
      .a    (aDigit[i]),
      .b    (bDigit[i]),
      .cin  (chain[i]),
      .sel  (selReg),
      .res  (sliceRes[i]),
      .cout (chain[i+1])
    );
  end

  // Result with the current digit dropped into place. Built combinationally
  // so the zero flag can be judged on the final value at the same edge that
  // writes the last digit.
  always_comb begin
    resMerged = ResAlu;
    resMerged[int'(digitCnt)*SLICES +: SLICES] = sliceRes;
  end

  // Datapath and registered handshake outputs. Ready/Valid are derived from
  // the next state so they change on the same edge as the state itself and
  // never depend combinationally on inputs. The carry register is loaded
  // with 0 for logic ops so stale carries never leak into them.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      Ready    <= 1'b1;
      Valid    <= 1'b0;
      digitCnt <= '0;
      aReg     <= '0;
      bReg     <= '0;
      selReg   <= OP_AND;
      carryReg <= 1'b0;
      ResAlu   <= '0;
      CarryOut <= 1'b0;
`ifdef ALU_SERIAL_FLAGS_EN
      Zero     <= 1'b0;
      Overflow <= 1'b0;
`endif
    end else begin
      Ready <= (stateNext == IDLE);
      Valid <= (stateNext == DONE);
      if (accept) begin
        aReg     <= A;
        bReg     <= B;
        selReg   <= Sel;
        carryReg <= isArith(Sel) & CarryIn;
        digitCnt <= '0;
      end else if (state == RUN) begin
        ResAlu   <= resMerged;
        carryReg <= chain[SLICES];
        digitCnt <= digitCnt + 1'b1;
        if (lastDigit) begin
          CarryOut <= chain[SLICES];
`ifdef ALU_SERIAL_FLAGS_EN
          Zero     <= (resMerged == '0);
          Overflow <= isArith(selReg) & (chain[SLICES-1] ^ chain[SLICES]);
`endif
        end
      end
    end
  end

endmodule
